// File: rtl/rfm_act_sched_pkg.sv
// Shared RFM package: scheduler FSM encoding and default ACT/RFM timing constants.
// Used by rfm_act_sched, whose optional statistics build is selected by RFM_ACT_SCHED_STAT_EN.
package rfm_act_sched_pkg;

  typedef enum logic {
    ST_READY = 1'b0,
    ST_GAP   = 1'b1
  } sched_state_e;

  localparam int DEF_CMD_GAP = 4;
  localparam int DEF_RFM_TH  = 8;

  // Width of a down-counter that must hold gap-1 (at least one bit).
  function automatic int gap_width(input int gap);
    return (gap > 2) ? $clog2(gap) : 1;
  endfunction

endpackage

// File: rtl/rfm_addr_fifo.sv
// Small FIFO for ACT row addresses; head word is visible on data while not empty.
// DEPTH must be a power of two, at least 2.
module rfm_addr_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW:0]      count_reg;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count_reg == (PW+1)'(DEPTH));
  assign empty = (count_reg == '0);
  assign rd_en = pop & ~empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign wr_en = push & (~full | rd_en);
  assign data  = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/rfm_act_sched.sv
// ACT/RFM command scheduler: buffers ACT requests, spaces commands by CMD_GAP, inserts RFM at RFM_TH.
// Define RFM_ACT_SCHED_STAT_EN to add the act_total/rfm_total pulse counters.
module rfm_act_sched
  import rfm_act_sched_pkg::*;
#(
  parameter int ADDR_SIZE  = 18,
  parameter int RFM_TH     = DEF_RFM_TH,
  parameter int FIFO_DEPTH = 4,
  parameter int CMD_GAP    = DEF_CMD_GAP,
  parameter int RAA_SIZE   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADDR_SIZE-1:0] in_addr,
  output logic                 act_cmd,
  output logic [ADDR_SIZE-1:0] act_addr,
  output logic                 rfm_cmd,
  output logic [RAA_SIZE-1:0]  raa_cnt
`ifdef RFM_ACT_SCHED_STAT_EN
  ,
  output logic [31:0]          act_total,
  output logic [31:0]          rfm_total
`endif
);

  localparam int                 GAP_W    = gap_width(CMD_GAP);
  localparam logic [GAP_W-1:0]   GAP_LOAD = GAP_W'(CMD_GAP - 1);
  localparam logic [RAA_SIZE-1:0] RAA_TH  = RAA_SIZE'(RFM_TH);
  localparam logic [RAA_SIZE-1:0] RAA_MAX = '1;

  sched_state_e         state_reg;
  logic [GAP_W-1:0]     gap_cnt_reg;
  logic                 act_cmd_reg;
  logic                 rfm_cmd_reg;
  logic [ADDR_SIZE-1:0] act_addr_reg;
  logic [RAA_SIZE-1:0]  raa_reg;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [ADDR_SIZE-1:0] fifo_data;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 accept;
  logic                 slot_open;
  logic                 rfm_due;
  logic                 bypass;
  logic                 issue;

  rfm_addr_fifo #(
    .WIDTH (ADDR_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (in_addr),
    .full  (fifo_full),
    .empty (fifo_empty),
    .data  (fifo_data)
  );

  assign in_ready  = ~fifo_full;
  assign accept    = in_valid & in_ready;
  assign slot_open = (state_reg == ST_READY);
  assign rfm_due   = (raa_reg >= RAA_TH);
  assign fifo_pop  = slot_open & ~rfm_due & ~fifo_empty;
  // An idle scheduler issues a fresh request straight from the input, skipping the FIFO.
  assign bypass    = slot_open & ~rfm_due & fifo_empty & accept;
  assign fifo_push = accept & ~bypass;
  assign issue     = slot_open & (rfm_due | ~fifo_empty | accept);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_READY;
      gap_cnt_reg  <= '0;
      act_cmd_reg  <= 1'b0;
      rfm_cmd_reg  <= 1'b0;
      act_addr_reg <= '0;
      raa_reg      <= '0;
    end else begin
      act_cmd_reg <= 1'b0;
      rfm_cmd_reg <= 1'b0;

      if (act_cmd_reg) begin
        if (raa_reg != RAA_MAX) begin
          raa_reg <= raa_reg + 1'b1;
        end
      end else if (rfm_cmd_reg) begin
        raa_reg <= (raa_reg > RAA_TH) ? (raa_reg - RAA_TH) : '0;
      end

      case (state_reg)
        ST_READY: begin
          if (rfm_due) begin
            rfm_cmd_reg <= 1'b1;
          end else if (fifo_pop) begin
            act_cmd_reg  <= 1'b1;
            act_addr_reg <= fifo_data;
          end else if (bypass) begin
            act_cmd_reg  <= 1'b1;
            act_addr_reg <= in_addr;
          end
          if (issue) begin
            gap_cnt_reg <= GAP_LOAD;
            state_reg   <= (CMD_GAP > 1) ? ST_GAP : ST_READY;
          end
        end
        ST_GAP: begin
          // Leaving GAP as the counter hits zero keeps pulses exactly CMD_GAP apart.
          gap_cnt_reg <= (gap_cnt_reg != '0) ? (gap_cnt_reg - 1'b1) : '0;
          if (gap_cnt_reg <= GAP_W'(1)) begin
            state_reg <= ST_READY;
          end
        end
        default: state_reg <= ST_READY;
      endcase
    end
  end

  assign act_cmd  = act_cmd_reg;
  assign rfm_cmd  = rfm_cmd_reg;
  assign act_addr = act_addr_reg;
  assign raa_cnt  = raa_reg;

`ifdef RFM_ACT_SCHED_STAT_EN
  logic [31:0] act_total_reg;
  logic [31:0] rfm_total_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_total_reg <= '0;
      rfm_total_reg <= '0;
    end else begin
      if (act_cmd_reg) begin
        act_total_reg <= act_total_reg + 32'd1;
      end
      if (rfm_cmd_reg) begin
        rfm_total_reg <= rfm_total_reg + 32'd1;
      end
    end
  end

  assign act_total = act_total_reg;
  assign rfm_total = rfm_total_reg;
`else
  // Plain build: no statistics counters.
`endif

endmodule
